// File: rtl/lock_seq_pkg.sv
// Shared types and default widths for the lock key sequencer.
package lock_seq_pkg;

    localparam int KEY_W = 8;
    localparam int IN_W  = 8;
    localparam int OUT_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/key_shift_reg.sv
// Serial-to-parallel shadow register for the activation key, LSB first.
module key_shift_reg #(
    parameter int KEY_W = lock_seq_pkg::KEY_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             key_bit,
    output logic             last,
    output logic [KEY_W-1:0] value
);

    localparam int CNT_W = $clog2(KEY_W) + 1;
    localparam int IDX_W = CNT_W - 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [KEY_W-1:0] shadow_q, shadow_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (shift_en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        shadow_d = shadow_q;
        if (shift_en) begin
            shadow_d[cnt_q[IDX_W-1:0]] = key_bit;
        end
    end

    // value includes the bit being accepted so the top can commit on the same edge
    assign last  = shift_en && (cnt_q == CNT_W'(KEY_W - 1));
    assign value = shadow_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // every bit is rewritten before a commit, so the shadow needs no reset
    always_ff @(posedge clk) begin
        shadow_q <= shadow_d;
    end

endmodule

// File: rtl/lock_key_sequencer.sv
// Key loading, commit and two-stage data wrapper in front of the locked core.
//   state | meaning
//   IDLE  | no key committed yet, core results blocked
//   LOAD  | accepting serial key bits into the shadow register
//   RUN   | key committed, vectors stream through the wrapper
//   DRAIN | re-key requested, waiting for the wrapper to empty
module lock_key_sequencer #(
    parameter int KEY_W = lock_seq_pkg::KEY_W,
    parameter int IN_W  = lock_seq_pkg::IN_W,
    parameter int OUT_W = lock_seq_pkg::OUT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_start,
    input  logic             key_valid,
    input  logic             key_bit,
    output logic             key_ready,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    input  logic             out_ready,
    output logic [IN_W-1:0]  core_in,
    output logic [KEY_W-1:0] core_key,
    input  logic [OUT_W-1:0] core_out,
    output logic             key_loaded,
    output logic             busy
);

    import lock_seq_pkg::*;

    state_t             state_q, state_d;
    logic [KEY_W-1:0]   core_key_q, core_key_d;
    logic               key_loaded_q, key_loaded_d;
    logic [IN_W-1:0]    core_in_q, core_in_d;
    logic               s1_v_q, s1_v_d;
    logic [OUT_W-1:0]   out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;

    logic               key_accept;
    logic               key_last;
    logic               cnt_clear;
    logic [KEY_W-1:0]   shadow_val;
    logic               s2_load;
    logic               in_fire;
    logic               pipe_empty;

    assign pipe_empty = !s1_v_q && !out_valid_q;
    assign key_ready  = (state_q == LOAD);
    assign busy       = (state_q == LOAD) || (state_q == DRAIN);
    assign key_accept = key_valid && key_ready;
    assign cnt_clear  = ((state_q == IDLE) && load_start) ||
                        ((state_q == DRAIN) && pipe_empty);

    key_shift_reg #(.KEY_W(KEY_W)) u_key_shift_reg (
        .clk      (clk),
        .rst      (rst),
        .clear    (cnt_clear),
        .shift_en (key_accept),
        .key_bit  (key_bit),
        .last     (key_last),
        .value    (shadow_val)
    );

    always_comb begin
        state_d      = state_q;
        core_key_d   = core_key_q;
        key_loaded_d = key_loaded_q;
        case (state_q)
            IDLE: begin
                if (load_start) state_d = LOAD;
            end
            LOAD: begin
                if (key_last) begin
                    core_key_d   = shadow_val;
                    key_loaded_d = 1'b1;
                    state_d      = RUN;
                end
            end
            RUN: begin
                if (load_start) state_d = DRAIN;
            end
            DRAIN: begin
                if (pipe_empty) state_d = LOAD;
            end
            default: state_d = IDLE;
        endcase
    end

    // stage 2 frees up either when empty or when its result leaves this cycle
    assign s2_load  = s1_v_q && (!out_valid_q || out_ready);
    assign in_ready = (state_q == RUN) && (!s1_v_q || s2_load);
    assign in_fire  = in_valid && in_ready;

    always_comb begin
        core_in_d   = core_in_q;
        s1_v_d      = s1_v_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (in_fire) begin
            core_in_d = in_data;
            s1_v_d    = 1'b1;
        end else if (s2_load) begin
            s1_v_d = 1'b0;
        end
        if (s2_load) begin
            out_data_d  = core_out;
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            core_key_q   <= '0;
            key_loaded_q <= 1'b0;
            core_in_q    <= '0;
            s1_v_q       <= 1'b0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            core_key_q   <= core_key_d;
            key_loaded_q <= key_loaded_d;
            core_in_q    <= core_in_d;
            s1_v_q       <= s1_v_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign core_key   = core_key_q;
    assign key_loaded = key_loaded_q;
    assign core_in    = core_in_q;
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_lock_key_sequencer.sv
// Bench for lock_key_sequencer: transaction-level model plus directed literal checks.
module tb_lock_key_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load_start = 1'b0;
    logic       key_valid = 1'b0;
    logic       key_bit = 1'b0;
    logic       key_ready;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       out_valid;
    logic [1:0] out_data;
    logic       out_ready = 1'b1;
    logic [7:0] core_in;
    logic [7:0] core_key;
    logic [1:0] core_out;
    logic       key_loaded;
    logic       busy;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lock_key_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .key_valid  (key_valid),
        .key_bit    (key_bit),
        .key_ready  (key_ready),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .core_in    (core_in),
        .core_key   (core_key),
        .core_out   (core_out),
        .key_loaded (key_loaded),
        .busy       (busy)
    );

    // stand-in for the locked core: bit 4 of the key blocks, bit 0 flips
    function automatic logic [1:0] core_fn(input logic [7:0] din, input logic [7:0] k);
        logic b;
        b = (din[0] ^ k[0]) & ~k[4];
        return {b ^ (din[7] & k[7]), b ^ (din[6] & k[6])};
    endfunction

    assign core_out = core_fn(core_in, core_key);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // model: mode flags, committed key, and FIFO of results in flight
    typedef struct {
        logic [1:0] res;
        int         edge_n;
    } item_t;

    item_t      m_q[$];
    bit         model_valid = 1'b0;
    bit         m_loading = 1'b0;
    bit         m_draining = 1'b0;
    bit         m_have_key = 1'b0;
    logic [7:0] m_key = 8'h00;
    logic [7:0] m_shadow = 8'h00;
    int         m_nbits = 0;
    int         edge_cnt = 0;

    logic [1:0] seen[$];
    int         seen_edge[$];
    int         acc_cnt = 0;

    always @(negedge clk) begin : compare_and_model
        bit    run_m;
        bit    exp_ir;
        bit    exp_ov;
        bit    empty_pre;
        item_t it;

        run_m  = m_have_key && !m_loading && !m_draining;
        exp_ir = run_m && (m_q.size() < 2 || out_ready);
        exp_ov = (m_q.size() > 0) && (m_q[0].edge_n < edge_cnt);

        if (model_valid) begin
            chk("key_ready", key_ready, m_loading);
            chk("busy", busy, m_loading || m_draining);
            chk("key_loaded", key_loaded, m_have_key);
            chk("core_key", core_key, m_key);
            chk("in_ready", in_ready, exp_ir);
            chk("out_valid", out_valid, exp_ov);
            if (exp_ov) chk("out_data", out_data, m_q[0].res);
            if (out_valid && out_ready) begin
                seen.push_back(out_data);
                seen_edge.push_back(edge_cnt);
            end
            if (in_valid && in_ready) acc_cnt++;
        end

        // advance the model across the coming rising edge
        edge_cnt++;
        if (rst) begin
            model_valid = 1'b1;
            m_loading   = 1'b0;
            m_draining  = 1'b0;
            m_have_key  = 1'b0;
            m_key       = 8'h00;
            m_nbits     = 0;
            m_q.delete();
        end else begin
            empty_pre = (m_q.size() == 0);
            if (exp_ov && out_ready) void'(m_q.pop_front());
            if (in_valid && exp_ir) begin
                it.res    = core_fn(in_data, m_key);
                it.edge_n = edge_cnt;
                m_q.push_back(it);
            end
            if (m_loading) begin
                if (key_valid) begin
                    m_shadow[m_nbits] = key_bit;
                    m_nbits++;
                    if (m_nbits == 8) begin
                        m_key      = m_shadow;
                        m_have_key = 1'b1;
                        m_loading  = 1'b0;
                    end
                end
            end else if (!m_have_key) begin
                if (load_start) begin
                    m_loading = 1'b1;
                    m_nbits   = 0;
                end
            end else if (m_draining) begin
                if (empty_pre) begin
                    m_draining = 1'b0;
                    m_loading  = 1'b1;
                    m_nbits    = 0;
                end
            end else if (load_start) begin
                m_draining = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_key_ready();
        for (int n = 0; n < 40 && !key_ready; n++) step();
        chk("key_ready_wait", key_ready, 1'b1);
    endtask

    task automatic send_bits(input logic [7:0] k);
        wait_key_ready();
        for (int i = 0; i < 8; i++) begin
            key_valid = 1'b1;
            key_bit   = k[i];
            step();
        end
        key_valid = 1'b0;
    endtask

    task automatic load_key(input logic [7:0] k);
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        send_bits(k);
    endtask

    logic [7:0] bp_data[3];

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        // idle: inputs offered but nothing accepted
        in_valid = 1'b1;
        in_data  = 8'h11;
        for (int i = 0; i < 10; i++) step();
        chk("idle_in_ready", in_ready, 1'b0);
        chk("idle_out_valid", out_valid, 1'b0);
        chk("idle_core_key", core_key, 8'h00);
        in_valid = 1'b0;

        // key 8'h01, two vectors back to back
        load_key(8'h01);
        chk("key01_commit", core_key, 8'h01);
        chk("key01_in_ready", in_ready, 1'b1);
        seen.delete();
        seen_edge.delete();
        in_valid = 1'b1;
        in_data  = 8'h11;
        step();
        in_data = 8'h10;
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("k01_count", seen.size(), 2);
        if (seen.size() == 2) begin
            chk("k01_res0", seen[0], 2'b00);
            chk("k01_res1", seen[1], 2'b11);
            chk("k01_consecutive", seen_edge[1] - seen_edge[0], 1);
        end

        // key 8'h10 keeps the core locked
        load_key(8'h10);
        chk("key10_commit", core_key, 8'h10);
        seen.delete();
        in_valid = 1'b1;
        in_data  = 8'h10;
        step();
        in_data = 8'h11;
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("k10_count", seen.size(), 2);
        if (seen.size() == 2) begin
            chk("k10_res0", seen[0], 2'b00);
            chk("k10_res1", seen[1], 2'b00);
        end

        // backpressure: three offered, two fit
        load_key(8'h01);
        bp_data[0] = 8'h11;
        bp_data[1] = 8'h10;
        bp_data[2] = 8'h01;
        seen.delete();
        acc_cnt   = 0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = bp_data[acc_cnt < 3 ? acc_cnt : 2];
            step();
        end
        chk("bp_accepted", acc_cnt, 2);
        chk("bp_hold_data", out_data, 2'b00);
        step();
        chk("bp_still_held", out_data, 2'b00);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        step();
        chk("bp_count", seen.size(), 2);
        if (seen.size() == 2) begin
            chk("bp_res0", seen[0], 2'b00);
            chk("bp_res1", seen[1], 2'b11);
        end

        // re-key with one result pending
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h11;
        step();
        in_valid   = 1'b0;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        step();
        step();
        chk("drain_busy", busy, 1'b1);
        chk("drain_key_ready", key_ready, 1'b0);
        chk("drain_old_key", core_key, 8'h01);
        chk("drain_pending", out_valid, 1'b1);
        out_ready = 1'b1;
        wait_key_ready();
        chk("rekey_old_key", core_key, 8'h01);
        chk("rekey_busy", busy, 1'b1);
        send_bits(8'h10);
        chk("rekey_new_key", core_key, 8'h10);

        // reset in the middle of a load
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        wait_key_ready();
        for (int i = 0; i < 4; i++) begin
            key_valid = 1'b1;
            key_bit   = i[0];
            step();
        end
        key_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_key_loaded", key_loaded, 1'b0);
        chk("rst_key_ready", key_ready, 1'b0);
        chk("rst_core_key", core_key, 8'h00);
        chk("rst_busy", busy, 1'b0);
        load_key(8'h01);
        chk("reload_key", core_key, 8'h01);
        chk("reload_loaded", key_loaded, 1'b1);

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rst        = ($urandom_range(0, 499) == 0);
            load_start = ($urandom_range(0, 39) == 0);
            key_valid  = ($urandom_range(0, 2) != 0);
            key_bit    = 1'($urandom_range(0, 1));
            in_valid   = ($urandom_range(0, 2) != 0);
            in_data    = 8'($urandom_range(0, 255));
            out_ready  = ($urandom_range(0, 3) != 0);
            step();
        end
        rst        = 1'b0;
        load_start = 1'b0;
        key_valid  = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
